alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's combinational 16-bit ALU. Accepts one operation per transfer on a valid/ready input port and returns a registered result plus flags on a valid/ready output port. Adds XOR, add-with-carry, subtract-with-borrow, shifts, an iterative multiplier and an overflow flag. It sits between the operand/decode stage and the writeback stage of the datapath.

---
 rtl/alu_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU between decode and writeback.
// Build option: define ALU_MUL_EN to include the iterative multiplier.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready operation handshake (op, A, B)
//   out_valid/out_ready result handshake (alu_out, flags, err)
//   flags             [3] overflow [2] sign [1] zero [0] carry
//   err               illegal opcode, qualified by out_valid
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int M = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_CMP = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NTA = 4'h6;
  localparam logic [3:0] OP_NTB = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_ADC = 4'h9;
  localparam logic [3:0] OP_SBB = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hB;
`endif

  logic             carry_q;
  logic             accept;

  logic [WIDTH:0]   ax;
  logic [WIDTH:0]   bx;
  logic [WIDTH:0]   cx;
  logic [WIDTH:0]   s_add;
  logic [WIDTH:0]   s_sub;
  logic [WIDTH:0]   s_inc;
  logic [WIDTH:0]   s_adc;
  logic [WIDTH:0]   s_sbb;
  logic [WIDTH:0]   shl_x;
  logic [WIDTH:0]   shr_x;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] c_res;
  logic [WIDTH-1:0] c_val;
  logic [3:0]       c_flags;
  logic             c_c;
  logic             c_v;
  logic             c_err;
  logic             c_mul;

  assign ax    = {1'b0, A};
  assign bx    = {1'b0, B};
  assign cx    = {{WIDTH{1'b0}}, carry_q};
  assign s_add = ax + bx;
  assign s_sub = ax - bx;
  assign s_inc = ax + {{WIDTH{1'b0}}, 1'b1};
  assign s_adc = ax + bx + cx;
  assign s_sbb = ax - bx - cx;
  assign shamt = B[SHW-1:0];
  // Extra bit on the outgoing side catches
  // the last bit shifted out; zero shift
  // leaves it at 0.
  assign shl_x = {1'b0, A} << shamt;
  assign shr_x = {A, 1'b0} >> shamt;

  always_comb begin
    c_res = '0;
    c_val = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    c_err = 1'b0;
    c_mul = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        c_val = s_add[M:0];
        c_res = c_val;
        c_c   = s_add[WIDTH];
        c_v   = (A[M] == B[M]) &&
                (c_val[M] != A[M]);
      end
      (op == OP_SUB): begin
        c_val = s_sub[M:0];
        c_res = c_val;
        c_c   = s_sub[WIDTH];
        c_v   = (A[M] != B[M]) &&
                (c_val[M] != A[M]);
      end
      (op == OP_CMP): begin
        // flags from the difference,
        // output forced to zero
        c_val = s_sub[M:0];
        c_c   = s_sub[WIDTH];
        c_v   = (A[M] != B[M]) &&
                (c_val[M] != A[M]);
      end
      (op == OP_INC): begin
        c_val = s_inc[M:0];
        c_res = c_val;
        c_c   = s_inc[WIDTH];
        c_v   = !A[M] && c_val[M];
      end
      (op == OP_AND): begin
        c_val = A & B;
        c_res = c_val;
      end
      (op == OP_OR): begin
        c_val = A | B;
        c_res = c_val;
      end
      (op == OP_NTA): begin
        c_val = ~A;
        c_res = c_val;
      end
      (op == OP_NTB): begin
        c_val = ~B;
        c_res = c_val;
      end
      (op == OP_XOR): begin
        c_val = A ^ B;
        c_res = c_val;
      end
      (op == OP_ADC): begin
        c_val = s_adc[M:0];
        c_res = c_val;
        c_c   = s_adc[WIDTH];
        c_v   = (A[M] == B[M]) &&
                (c_val[M] != A[M]);
      end
      (op == OP_SBB): begin
        c_val = s_sbb[M:0];
        c_res = c_val;
        c_c   = s_sbb[WIDTH];
        c_v   = (A[M] != B[M]) &&
                (c_val[M] != A[M]);
      end
      (op == OP_SHL): begin
        c_val = shl_x[M:0];
        c_res = c_val;
        c_c   = shl_x[WIDTH];
      end
      (op == OP_SHR): begin
        c_val = shr_x[WIDTH:1];
        c_res = c_val;
        c_c   = shr_x[0];
      end
`ifdef ALU_MUL_EN
      (op == OP_MUL): begin
        c_mul = 1'b1;
      end
`endif
      default: begin
        c_err = 1'b1;
      end
    endcase
    if (c_err)
      c_flags = 4'b0000;
    else
      c_flags = {c_v, c_val[M],
                 (c_val == '0), c_c};
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;
  logic               mul_done;
  logic [WIDTH-1:0]   m_res;
  logic [3:0]         m_flags;

  assign prod_nx  = prod +
                    (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(WIDTH - 1));
  assign mul_done = (state == MUL_BUSY) &&
                    mul_last;
  assign m_res    = prod_nx[M:0];
  assign m_flags  = {1'b0, m_res[M],
                     (m_res == '0),
                     |prod_nx[2*WIDTH-1:WIDTH]};
  assign in_ready = (state == IDLE) &&
                    (!out_valid || out_ready);
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags     <= 4'b0000;
      err       <= 1'b0;
      carry_q   <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= IDLE;
      mcand     <= '0;
      prod      <= '0;
      mplier    <= '0;
      cnt       <= '0;
`endif
    end else begin
      if (accept && !c_mul) begin
        out_valid <= 1'b1;
        alu_out   <= c_res;
        flags     <= c_flags;
        err       <= c_err;
        if (!c_err)
          carry_q <= c_flags[0];
      end
`ifdef ALU_MUL_EN
      else if (mul_done) begin
        out_valid <= 1'b1;
        alu_out   <= m_res;
        flags     <= m_flags;
        err       <= 1'b0;
        carry_q   <= m_flags[0];
      end
`endif
      else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        alu_out   <= '0;
        flags     <= 4'b0000;
        err       <= 1'b0;
      end
`ifdef ALU_MUL_EN
      unique case (state)
        IDLE: begin
          if (accept && c_mul) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            prod   <= '0;
            cnt    <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          prod   <= prod_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq.
// Expected results queue up at issue, compared on transfer.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic [3:0]   flags;
  logic         err;

  int total = 0;
  int bad = 0;
  bit cq = 1'b0;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t mon_g;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out(alu_out),
    .flags(flags),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_g = {alu_out, flags, err};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h/%b/%b",
                 alu_out, flags, err);
      end else begin
        mon_e = q.pop_front();
        if (mon_g !== mon_e) begin
          bad++;
          $display("FAIL result got=%h/%b/%b want=%h/%b/%b",
                   alu_out, flags, err,
                   mon_e.r, mon_e.f, mon_e.e);
        end
      end
    end
  end

  function automatic exp_t model(
    input logic [3:0]   o,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input bit           cin
  );
    longint ua, ub, sa, sb, u, s, ci;
    int n;
    bit c, v, er, ar;
    logic [W-1:0] r, fv;
    exp_t e;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = longint'(cin);
    n  = int'(b[3:0]);
    u = 0; s = 0; c = 0; v = 0;
    er = 0; ar = 0; r = '0; fv = '0;
    case (o)
      4'h0: begin
        u = ua + ub; s = sa + sb; c = u[W]; ar = 1;
      end
      4'h1, 4'h2: begin
        u = ua - ub; s = sa - sb; c = (ua < ub); ar = 1;
      end
      4'h3: begin
        u = ua + 1; s = sa + 1; c = u[W]; ar = 1;
      end
      4'h4: fv = a & b;
      4'h5: fv = a | b;
      4'h6: fv = ~a;
      4'h7: fv = ~b;
      4'h8: fv = a ^ b;
      4'h9: begin
        u = ua + ub + ci; s = sa + sb + ci;
        c = u[W]; ar = 1;
      end
      4'hA: begin
        u = ua - ub - ci; s = sa - sb - ci;
        c = (ua < ub + ci); ar = 1;
      end
`ifdef ALU_MUL_EN
      4'hB: begin
        u = ua * ub;
        fv = u[W-1:0];
        c = ((u >> W) != 0);
      end
`endif
      4'hC: begin
        u = ua << n;
        fv = u[W-1:0];
        c = (n == 0) ? 1'b0 : a[W-n];
      end
      4'hD: begin
        u = ua >> n;
        fv = u[W-1:0];
        c = (n == 0) ? 1'b0 : a[n-1];
      end
      default: er = 1;
    endcase
    if (ar) begin
      fv = u[W-1:0];
      v = (s > 32767) || (s < -32768);
    end
    r = (o == 4'h2) ? '0 : fv;
    e.r = er ? '0 : r;
    e.f = er ? 4'b0000 : {v, fv[W-1], (fv == '0), c};
    e.e = er;
    return e;
  endfunction

  task automatic send(
    input  logic [3:0]   o,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output int           waits
  );
    bit r;
    op = o; A = a; B = b;
    in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waits++;
      if (waits > 100) begin
        total++; bad++;
        $display("FAIL accept_timeout got=stuck want=accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run(
    input  logic [3:0]   o,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output int           waits
  );
    exp_t e;
    e = model(o, a, b, cq);
    if (!e.e) cq = e.f[0];
    q.push_back(e);
    send(o, a, b, waits);
  endtask

  task automatic run_c(
    input  logic [3:0]   o,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] r,
    input  logic [3:0]   f,
    input  logic         er,
    output int           waits
  );
    exp_t e;
    e.r = r; e.f = f; e.e = er;
    if (!er) cq = f[0];
    q.push_back(e);
    send(o, a, b, waits);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W+6:0] got;
    #1;
    got = {in_ready, out_valid, alu_out, flags, err};
    total++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 4'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_active got=%h want=%h", got,
               {1'b1, 1'b0, {W{1'b0}}, 4'b0, 1'b0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got = {in_ready, out_valid, alu_out, flags, err};
    total++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 4'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", got,
               {1'b1, 1'b0, {W{1'b0}}, 4'b0, 1'b0});
    end
  endtask

  task automatic test_add();
    int w;
    run_c(4'h0, 16'hFFFF, 16'h0001,
          16'h0000, 4'b0011, 1'b0, w);
    total++;
    if (out_valid !== 1'b1 || w !== 0) begin
      bad++;
      $display("FAIL add_latency got=v%b w%0d want=v1 w0",
               out_valid, w);
    end
    drain();
  endtask

  task automatic test_sub_sbb();
    int w;
    run_c(4'h1, 16'h0000, 16'h0001,
          16'hFFFF, 4'b0101, 1'b0, w);
    run_c(4'hA, 16'h0005, 16'h0002,
          16'h0002, 4'b0000, 1'b0, w);
    drain();
  endtask

  task automatic test_cmp_ovf();
    int w;
    run_c(4'h2, 16'h1234, 16'h1234,
          16'h0000, 4'b0010, 1'b0, w);
    run_c(4'h0, 16'h7FFF, 16'h0001,
          16'h8000, 4'b1100, 1'b0, w);
    run_c(4'h2, 16'h0001, 16'h0002,
          16'h0000, 4'b0101, 1'b0, w);
    drain();
  endtask

  task automatic test_logic_shift();
    int w;
    run_c(4'h8, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000, 1'b0, w);
    run_c(4'h4, 16'h00FF, 16'h0F0F, 16'h000F, 4'b0000, 1'b0, w);
    run_c(4'h6, 16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 1'b0, w);
    run_c(4'h7, 16'h1234, 16'hFFFF, 16'h0000, 4'b0010, 1'b0, w);
    run_c(4'h3, 16'h7FFF, 16'h0000, 16'h8000, 4'b1100, 1'b0, w);
    run_c(4'hC, 16'h8001, 16'h0001, 16'h0002, 4'b0001, 1'b0, w);
    run_c(4'hD, 16'h0001, 16'h0001, 16'h0000, 4'b0011, 1'b0, w);
    run_c(4'hC, 16'h8001, 16'h0000, 16'h8001, 4'b0100, 1'b0, w);
    run_c(4'hD, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b0, w);
    drain();
  endtask

  task automatic test_mul();
    int w;
    int n;
`ifdef ALU_MUL_EN
    run_c(4'hB, 16'h0100, 16'h0100,
          16'h0000, 4'b0011, 1'b0, w);
    n = 0;
    while (in_ready === 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== W || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mul_busy got=%0d v%b want=%0d v1",
               n, out_valid, W);
    end
    drain();
    run_c(4'hB, 16'h0003, 16'h0005,
          16'h000F, 4'b0000, 1'b0, w);
    drain();
    run(4'hB, 16'hBEEF, 16'h1357, w);
    drain();
`else
    run_c(4'hB, 16'h0003, 16'h0005,
          16'h0000, 4'b0000, 1'b1, w);
    n = 0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mulop_illegal_latency got=%b want=1",
               out_valid);
    end
    drain();
`endif
  endtask

  task automatic test_hold();
    int w;
    logic [W+1:0] got;
    out_ready = 1'b0;
    run_c(4'h0, 16'h0002, 16'h0003,
          16'h0005, 4'b0000, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = {out_valid, alu_out, in_ready};
      total++;
      if (got !== {1'b1, 16'h0005, 1'b0}) begin
        bad++;
        $display("FAIL hold got=%h want=%h", got,
                 {1'b1, 16'h0005, 1'b0});
      end
    end
    out_ready = 1'b1;
    run_c(4'h5, 16'h00F0, 16'h000F,
          16'h00FF, 4'b0000, 1'b0, w);
    total++;
    if (w !== 0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL replace got=w%0d v%b want=w0 v1",
               w, out_valid);
    end
    drain();
  endtask

  task automatic test_illegal();
    int w;
    run_c(4'hE, 16'h0001, 16'h0001,
          16'h0000, 4'b0000, 1'b1, w);
    run_c(4'h1, 16'h0000, 16'h0001,
          16'hFFFF, 4'b0101, 1'b0, w);
    run_c(4'hF, 16'h0000, 16'h0000,
          16'h0000, 4'b0000, 1'b1, w);
    run_c(4'h9, 16'h0000, 16'h0000,
          16'h0001, 4'b0000, 1'b0, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [3:0] o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 32; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'hB) o = 4'h9;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 5 == 0) a = 16'h7FFF;
      if (i % 7 == 0) b = 16'h8000;
      run(o, a, b, w);
      total++;
      if (w !== 0) begin
        bad++;
        $display("FAIL throughput got=%0d want=0 op=%h",
                 w, o);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    logic [W+6:0] got;
    run_c(4'h1, 16'h0000, 16'h0001,
          16'hFFFF, 4'b0101, 1'b0, w);
    drain();
`ifdef ALU_MUL_EN
    send(4'hB, 16'h1234, 16'h5678, w);
    repeat (5) @(posedge clk);
`else
    out_ready = 1'b0;
    run_c(4'h0, 16'h0001, 16'h0001,
          16'h0002, 4'b0000, 1'b0, w);
    repeat (2) @(posedge clk);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    cq = 1'b0;
    got = {in_ready, out_valid, alu_out, flags, err};
    total++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 4'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got=%h want=%h", got,
               {1'b1, 1'b0, {W{1'b0}}, 4'b0, 1'b0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL aborted_result got=%0d want=0", seen);
    end
    run_c(4'h9, 16'h0000, 16'h0000,
          16'h0000, 4'b0010, 1'b0, w);
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sbb();
    test_cmp_ovf();
    test_logic_shift();
    test_mul();
    test_hold();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
